// File: rtl/cnt_pkg.sv
// Shared slice width, nibble type and per-slice next-state function for the
// cascadable loadable counter.
package cnt_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef logic [SLICE_W-1:0] slice_t;

    function automatic slice_t slice_next(slice_t q, logic inc, logic up);
        slice_t r;
        r = q;
        if (inc) begin
            r = up ? q + slice_t'(1) : q - slice_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt4_slice.sv
// One 4-bit counter slice: registered nibble with clear/load/step priority and
// terminal-value flags for the lookahead chain. CNT_UPDN_EN adds all_zeros.
module cnt4_slice
    import cnt_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync_clr,
    input  logic               load,
    input  logic [SLICE_W-1:0] d,
    input  logic               cen,
    input  logic               up,
    output logic [SLICE_W-1:0] q,
    output logic               all_ones
`ifdef CNT_UPDN_EN
    ,
    output logic               all_zeros
`endif
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (sync_clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= slice_next(q, cen, up);
        end
    end

    assign all_ones = &q;
`ifdef CNT_UPDN_EN
    assign all_zeros = ~|q;
`endif

endmodule

// File: rtl/cnt_load_cascade.sv
// Cascadable loadable binary counter built from 4-bit slices with lookahead carry,
// ripple-carry out, wrap pulse and saturating wrap counter. CNT_UPDN_EN adds up_dn.
module cnt_load_cascade
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync_clr_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      d,
    input  logic                  en_p,
    input  logic                  en_t,
`ifdef CNT_UPDN_EN
    input  logic                  up_dn,
`endif
    output logic [WIDTH-1:0]      q,
    output logic                  rco,
    output logic                  tc_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    localparam int unsigned NS = WIDTH / SLICE_W;

    if ((WIDTH % SLICE_W) != 0 || WIDTH == 0) begin : g_width_check
        $error("cnt_load_cascade: WIDTH must be a non-zero multiple of 4");
    end

    logic          up;
    logic          step;
    logic          wrap;
    logic [NS-1:0] ones;
    logic [NS-1:0] flag;
    logic [NS:0]   chain;
`ifdef CNT_UPDN_EN
    logic [NS-1:0] zeros;
    assign up = up_dn;
`else
    assign up = 1'b1;
`endif

    assign step     = en_p & en_t;
    assign chain[0] = 1'b1;

    // chain[k] is the AND of terminal flags of slices below k: a flat AND tree,
    // no adder carry propagates between slices.
    for (genvar k = 0; k < NS; k++) begin : g_slice
`ifdef CNT_UPDN_EN
        assign flag[k] = up ? ones[k] : zeros[k];
`else
        assign flag[k] = ones[k];
`endif
        assign chain[k+1] = chain[k] & flag[k];

        cnt4_slice u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .sync_clr (~sync_clr_n),
            .load     (load),
            .d        (d[k*SLICE_W +: SLICE_W]),
            .cen      (step & chain[k]),
            .up       (up),
            .q        (q[k*SLICE_W +: SLICE_W]),
            .all_ones (ones[k])
`ifdef CNT_UPDN_EN
            ,
            .all_zeros(zeros[k])
`endif
        );
    end

    assign rco  = en_t & chain[NS];
    assign wrap = sync_clr_n & ~load & step & chain[NS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_pulse <= 1'b0;
            wrap_cnt <= '0;
        end else if (!sync_clr_n) begin
            tc_pulse <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            tc_pulse <= wrap;
            if (wrap && wrap_cnt != '1) begin
                wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cnt_load_cascade.sv
// Scoreboard bench for cnt_load_cascade: directed steps push expectations,
// a monitor pops and compares after each edge (and after an async reset).
module tb_cnt_load_cascade;

    typedef struct {
        logic [7:0] q;
        logic       rco;
        logic       tc;
        logic [7:0] wc;
        logic [1:0] wc2;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_clr_n = 1'b1;
    logic       load = 1'b0;
    logic [7:0] d = '0;
    logic       en_p = 1'b0;
    logic       en_t = 1'b0;
`ifdef CNT_UPDN_EN
    logic       up_dn = 1'b1;
    logic       dir_next = 1'b1;
`endif
    logic [7:0] q, q2;
    logic       rco, rco2, tc, tc2;
    logic [7:0] wc;
    logic [1:0] wc2;
    logic       async_chk = 1'b0;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cnt_load_cascade #(.WIDTH(8), .WRAP_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr_n(sync_clr_n), .load(load), .d(d),
        .en_p(en_p), .en_t(en_t),
`ifdef CNT_UPDN_EN
        .up_dn(up_dn),
`endif
        .q(q), .rco(rco), .tc_pulse(tc), .wrap_cnt(wc)
    );

    cnt_load_cascade #(.WIDTH(8), .WRAP_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .sync_clr_n(sync_clr_n), .load(load), .d(d),
        .en_p(en_p), .en_t(en_t),
`ifdef CNT_UPDN_EN
        .up_dn(up_dn),
`endif
        .q(q2), .rco(rco2), .tc_pulse(tc2), .wrap_cnt(wc2)
    );

    task automatic chk(input string tag, input string f, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h want %h", tag, f, act, exp);
        end
    endtask

    // Monitor: compares whenever an expectation is pending after an edge or async event.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge async_chk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "q",        q,        e.q);
                chk(e.tag, "rco",      8'(rco),  8'(e.rco));
                chk(e.tag, "tc_pulse", 8'(tc),   8'(e.tc));
                chk(e.tag, "wrap_cnt", wc,       e.wc);
                chk(e.tag, "q_sat",    q2,       e.q);
                chk(e.tag, "rco_sat",  8'(rco2), 8'(e.rco));
                chk(e.tag, "tc_sat",   8'(tc2),  8'(e.tc));
                chk(e.tag, "wrap_sat", 8'(wc2),  8'(e.wc2));
            end
        end
    end

    task automatic push(input logic [7:0] eq, input logic erco, input logic etc,
                        input logic [7:0] ewc, input logic [1:0] ewc2, input string tag);
        exp_t e;
        e.q = eq; e.rco = erco; e.tc = etc; e.wc = ewc; e.wc2 = ewc2; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic c, input logic ld, input logic [7:0] dd,
                        input logic ep, input logic et,
                        input logic [7:0] eq, input logic erco, input logic etc,
                        input logic [7:0] ewc, input logic [1:0] ewc2, input string tag);
        @(negedge clk);
        rst_n = r; sync_clr_n = c; load = ld; d = dd; en_p = ep; en_t = et;
`ifdef CNT_UPDN_EN
        up_dn = dir_next;
`endif
        push(eq, erco, etc, ewc, ewc2, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0, 8'd0, 2'd0, "reset");

        for (int i = 0; i < 259; i++) begin
            step(1, 1, 0, 8'h00, 1, 1, 8'(i + 1), (i == 254), (i == 255),
                 (i >= 255) ? 8'd1 : 8'd0, (i >= 255) ? 2'd1 : 2'd0, "run");
        end

        step(1, 1, 1, 8'hFE, 1, 1, 8'hFE, 0, 0, 8'd1, 2'd1, "load_fe");
        step(1, 1, 0, 8'h00, 1, 1, 8'hFF, 1, 0, 8'd1, 2'd1, "cnt_ff");
        step(1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 1, 8'd2, 2'd2, "wrap");
        step(1, 1, 1, 8'hFF, 1, 1, 8'hFF, 1, 0, 8'd2, 2'd2, "load_ff");
        step(1, 1, 0, 8'h00, 1, 0, 8'hFF, 0, 0, 8'd2, 2'd2, "ent_off");
        step(1, 1, 0, 8'h00, 1, 0, 8'hFF, 0, 0, 8'd2, 2'd2, "ent_off2");
        step(1, 1, 1, 8'h10, 1, 1, 8'h10, 0, 0, 8'd2, 2'd2, "load_not_wrap");

        step(1, 1, 1, 8'h5A, 1, 1, 8'h5A, 0, 0, 8'd2, 2'd2, "load_wins");
        step(1, 0, 1, 8'h5A, 1, 1, 8'h00, 0, 0, 8'd0, 2'd0, "clr_wins");

        step(1, 1, 1, 8'h0F, 1, 1, 8'h0F, 0, 0, 8'd0, 2'd0, "load_0f");
        step(1, 1, 0, 8'h00, 1, 1, 8'h10, 0, 0, 8'd0, 2'd0, "nibble");
        step(1, 1, 1, 8'h1F, 1, 1, 8'h1F, 0, 0, 8'd0, 2'd0, "load_1f");
        step(1, 1, 0, 8'h00, 0, 1, 8'h1F, 0, 0, 8'd0, 2'd0, "enp_off");
        step(1, 1, 0, 8'h00, 0, 1, 8'h1F, 0, 0, 8'd0, 2'd0, "enp_off2");

        step(1, 1, 1, 8'hFF, 1, 1, 8'hFF, 1, 0, 8'd0, 2'd0, "pre_ff");
        step(1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 1, 8'd1, 2'd1, "pre_wrap");
        step(1, 1, 1, 8'h7B, 1, 1, 8'h7B, 0, 0, 8'd1, 2'd1, "load_7b");
        step(1, 1, 0, 8'h00, 1, 1, 8'h7C, 0, 0, 8'd1, 2'd1, "cnt_7c");

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push(8'h00, 0, 0, 8'd0, 2'd0, "async_rst");
        async_chk = 1'b1;
        #2;
        async_chk = 1'b0;
        step(1, 1, 0, 8'h00, 1, 1, 8'h01, 0, 0, 8'd0, 2'd0, "release");

        for (int k = 1; k <= 5; k++) begin
            step(1, 1, 1, 8'hFF, 1, 1, 8'hFF, 1, 0, 8'(k - 1),
                 (k - 1 > 3) ? 2'd3 : 2'(k - 1), "sat_load");
            step(1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 1, 8'(k),
                 (k > 3) ? 2'd3 : 2'(k), "sat_wrap");
        end
        step(1, 1, 0, 8'h00, 1, 1, 8'h01, 0, 0, 8'd5, 2'd3, "tc_one_cycle");

`ifdef CNT_UPDN_EN
        dir_next = 1'b0;
        step(1, 1, 1, 8'h01, 1, 1, 8'h01, 0, 0, 8'd5, 2'd3, "dn_load");
        step(1, 1, 0, 8'h00, 1, 1, 8'h00, 1, 0, 8'd5, 2'd3, "dn_zero");
        step(1, 1, 0, 8'h00, 1, 1, 8'hFF, 0, 1, 8'd6, 2'd3, "dn_wrap");
        dir_next = 1'b1;
        step(1, 1, 0, 8'h00, 0, 1, 8'hFF, 1, 0, 8'd6, 2'd3, "up_rco");
`endif

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
